// File: rtl/genesis_bus_pkg.sv
// rtl/genesis_bus_pkg.sv - shared types and defaults for the Genesis bus arbiter
//
// Contents:
//   bus_state_t      : arbiter FSM states (IDLE, RAM, VDP, ACK)
//   target_t         : decoded access target (TGT_RAM, TGT_VDP)
//   VDP_BASE_DEFAULT : default base address of the VDP register window
//   VDP_MASK_DEFAULT : default mask selecting the VDP register window
package genesis_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM,
    VDP,
    ACK
  } bus_state_t;

  typedef enum logic {
    TGT_RAM,
    TGT_VDP
  } target_t;

  localparam logic [23:0] VDP_BASE_DEFAULT = 24'hC00000;
  localparam logic [23:0] VDP_MASK_DEFAULT = 24'hFFFFE0;

endpackage

// File: rtl/genesis_bus_arbiter_rr.sv
// rtl/genesis_bus_arbiter_rr.sv - round-robin grant selector with rotating pointer
//
// Ports:
//   clk     in  1 : system clock
//   rst_n   in  1 : synchronous active-low reset (pointer returns to 0)
//   req     in  N : request levels
//   advance in  1 : winner accepted; pointer moves to the slot after it
//   grant   out N : combinational one-hot winner (all zero when no request)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;

  // Scan from the farthest slot back to the pointer so the request closest
  // to the pointer is the last one written, i.e. it wins.
  always_comb begin
    int idx;
    grant = '0;
    win   = ptr;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (req[idx[PW-1:0]]) begin
        grant                = '0;
        grant[idx[PW-1:0]]   = 1'b1;
        win                  = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && |req) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/genesis_bus_arbiter.sv
// rtl/genesis_bus_arbiter.sv - multi-master arbiter and RAM/VDP decoder for the Genesis core
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   m_req/m_we            : per-master request level and write flag
//   m_addr/m_wdata/m_be   : packed per-master address, write data, byte enables
//   m_ack/m_berr          : one-hot access complete / bus error (held until req drops)
//   m_rdata               : read data, held until the next read capture
//   ram_en/ram_we         : one-cycle RAM strobe, write flag
//   ram_addr/wdata/be     : RAM word address, write data, byte enables
//   ram_rdata             : RAM read data, valid RAM_LAT cycles after ram_en
//   vdp_sel/vdp_rnw       : VDP select (held until dtack/timeout), read-not-write
//   vdp_a/vdp_di          : VDP register address and write data
//   vdp_do/vdp_dtack_n    : VDP read data and active-low acknowledge
module genesis_bus_arbiter
  import genesis_bus_pkg::*;
#(
  parameter int                N_MASTERS = 2,
  parameter int                ADDR_W    = 24,
  parameter int                DATA_W    = 16,
  parameter int                RAM_AW    = 15,
  parameter int                RAM_LAT   = 1,
  parameter logic [ADDR_W-1:0] VDP_BASE  = ADDR_W'(VDP_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] VDP_MASK  = ADDR_W'(VDP_MASK_DEFAULT),
  parameter int                VDP_TMO   = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_be,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_berr,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [RAM_AW-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [DATA_W/8-1:0]           ram_be,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic                          vdp_sel,
  output logic                          vdp_rnw,
  output logic [4:0]                    vdp_a,
  output logic [DATA_W-1:0]             vdp_di,
  input  logic [DATA_W-1:0]             vdp_do,
  input  logic                          vdp_dtack_n
);

  localparam int BW = DATA_W / 8;
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int TW = $clog2(VDP_TMO + 1);

  bus_state_t           state, state_d;
  logic [N_MASTERS-1:0] grant;
  logic [N_MASTERS-1:0] g_onehot;
  logic [IW-1:0]        win, g_q;
  logic                 we_q;
  logic [2:0]           lat_cnt;
  logic [TW-1:0]        tmo_cnt;

  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [BW-1:0]        sel_be;
  target_t              sel_tgt;

  logic start, ram_fin, vdp_ok, vdp_tmo, done, keep;

  rr_arbiter #(.N(N_MASTERS)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (m_req),
    .advance (start),
    .grant   (grant)
  );

  // Mux the winning master's request fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    win       = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant[i]) begin
        sel_we    = m_we[i];
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        sel_be    = m_be[i*BW +: BW];
        win       = IW'(i);
      end
    end
  end

  assign sel_tgt  = ((sel_addr & VDP_MASK) == VDP_BASE) ? TGT_VDP : TGT_RAM;
  assign g_onehot = N_MASTERS'(1) << g_q;
  assign keep     = m_req[g_q];

  assign start   = (state == IDLE) && |m_req;
  assign ram_fin = (state == RAM) && (we_q || lat_cnt == 3'(RAM_LAT));
  // dtack sampled in the same cycle the counter saturates still counts as success.
  assign vdp_ok  = (state == VDP) && !vdp_dtack_n;
  assign vdp_tmo = (state == VDP) && vdp_dtack_n && (tmo_cnt == TW'(VDP_TMO));
  assign done    = ram_fin || vdp_ok || vdp_tmo;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (start) state_d = (sel_tgt == TGT_VDP) ? VDP : RAM;
      RAM, VDP: if (done)  state_d = keep ? ACK : IDLE;
      ACK:      if (!keep) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q       <= '0;
      we_q      <= 1'b0;
      lat_cnt   <= '0;
      tmo_cnt   <= '0;
      m_ack     <= '0;
      m_berr    <= '0;
      m_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= '0;
      vdp_sel   <= 1'b0;
      vdp_rnw   <= 1'b1;
      vdp_a     <= '0;
      vdp_di    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            g_q     <= win;
            we_q    <= sel_we;
            lat_cnt <= '0;
            tmo_cnt <= '0;
            if (sel_tgt == TGT_VDP) begin
              vdp_sel <= 1'b1;
              vdp_rnw <= ~sel_we;
              vdp_a   <= sel_addr[4:0];
              vdp_di  <= sel_wdata;
            end else begin
              ram_en    <= 1'b1;
              ram_we    <= sel_we;
              ram_addr  <= sel_addr[RAM_AW:1];
              ram_wdata <= sel_wdata;
              ram_be    <= sel_be;
            end
          end
        end
        RAM: begin
          // The strobe is a single cycle; the access then completes even if
          // the master has already withdrawn its request.
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          if (ram_fin) begin
            if (!we_q) m_rdata <= ram_rdata;
            if (keep)  m_ack   <= g_onehot;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        VDP: begin
          if (tmo_cnt != TW'(VDP_TMO)) tmo_cnt <= tmo_cnt + 1'b1;
          if (vdp_ok) begin
            vdp_sel <= 1'b0;
            vdp_rnw <= 1'b1;
            if (!we_q) m_rdata <= vdp_do;
            if (keep)  m_ack   <= g_onehot;
          end else if (vdp_tmo) begin
            vdp_sel <= 1'b0;
            vdp_rnw <= 1'b1;
            if (!we_q) m_rdata <= '0;
            if (keep) begin
              m_ack  <= g_onehot;
              m_berr <= g_onehot;
            end
          end
        end
        ACK: begin
          if (!keep) begin
            m_ack  <= '0;
            m_berr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_genesis_bus_arbiter.sv
// tb/tb_genesis_bus_arbiter.sv - directed vector bench for genesis_bus_arbiter
module tb_genesis_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [47:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic [1:0]  m_ack, m_berr;
  logic [15:0] m_rdata;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [1:0]  ram_be;
  logic [15:0] ram_rdata;
  logic        vdp_sel, vdp_rnw;
  logic [4:0]  vdp_a;
  logic [15:0] vdp_di;
  logic [15:0] vdp_do = 16'h5A3C;
  logic        vdp_dtack_n = 1'b1;

  int errors = 0;
  int checks = 0;

  genesis_bus_arbiter #(
    .N_MASTERS(2), .ADDR_W(24), .DATA_W(16), .RAM_AW(15), .RAM_LAT(2),
    .VDP_BASE(24'hC00000), .VDP_MASK(24'hFFFFE0), .VDP_TMO(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_berr(m_berr), .m_rdata(m_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata),
    .vdp_sel(vdp_sel), .vdp_rnw(vdp_rnw), .vdp_a(vdp_a), .vdp_di(vdp_di),
    .vdp_do(vdp_do), .vdp_dtack_n(vdp_dtack_n)
  );

  always #5 clk = ~clk;

  // Two-cycle synchronous RAM model (RAM_LAT = 2).
  logic [15:0] mem [0:32767];
  logic [15:0] rd1, rd2;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
        if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      end
      rd1 <= mem[ram_addr];
    end
    rd2 <= rd1;
  end
  assign ram_rdata = rd2;

  typedef struct {
    int          m;
    bit          we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          dly;    // cycle in which dtack is driven low; 0 = never
    int          lat;    // expected ack cycle, strobe is cycle 1
    logic [15:0] rdata;
    bit          berr;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_master(input int m, input bit we, input logic [23:0] a,
                            input logic [15:0] d, input logic [1:0] be);
    m_we[m]          = we;
    m_addr[m*24 +: 24] = a;
    m_wdata[m*16 +: 16] = d;
    m_be[m*2 +: 2]   = be;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int cyc;
    bit is_vdp;
    logic [1:0] oh;
    oh = 2'b01 << v.m;
    is_vdp = ((v.addr & 24'hFFFFE0) == 24'hC00000);
    set_master(v.m, v.we, v.addr, v.wdata, v.be);
    m_req = oh;
    tick();
    cyc = 1;
    if (is_vdp) begin
      chk($sformatf("v%0d_vdp_sel", n), vdp_sel, 1);
      chk($sformatf("v%0d_vdp_a", n), vdp_a, v.addr[4:0]);
      chk($sformatf("v%0d_vdp_rnw", n), vdp_rnw, !v.we);
      if (v.we) chk($sformatf("v%0d_vdp_di", n), vdp_di, v.wdata);
    end else begin
      chk($sformatf("v%0d_ram_en", n), ram_en, 1);
      chk($sformatf("v%0d_ram_we", n), ram_we, v.we);
      chk($sformatf("v%0d_ram_addr", n), ram_addr, v.addr[15:1]);
      chk($sformatf("v%0d_ram_be", n), ram_be, v.be);
      if (v.we) chk($sformatf("v%0d_ram_wdata", n), ram_wdata, v.wdata);
    end
    while (m_ack == 2'b00 && cyc < 40) begin
      vdp_dtack_n = !(v.dly != 0 && cyc == v.dly);
      tick();
      cyc++;
      if (cyc == 2 && !is_vdp) chk($sformatf("v%0d_ram_en_pulse", n), ram_en, 0);
    end
    vdp_dtack_n = 1'b1;
    chk($sformatf("v%0d_ack_cycle", n), cyc, v.lat);
    chk($sformatf("v%0d_ack", n), m_ack, oh);
    chk($sformatf("v%0d_berr", n), m_berr, v.berr ? oh : 2'b00);
    if (!v.we) chk($sformatf("v%0d_rdata", n), m_rdata, v.rdata);
    if (is_vdp) chk($sformatf("v%0d_vdp_sel_drop", n), vdp_sel, 0);
    m_req = '0;
    tick();
    chk($sformatf("v%0d_ack_drop", n), m_ack, 0);
    chk($sformatf("v%0d_berr_drop", n), m_berr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int k;

    vecs[0]  = '{0, 1'b1, 24'h000010, 16'hBEEF, 2'b11, 0, 2,  16'h0000, 1'b0};
    vecs[1]  = '{0, 1'b0, 24'h000010, 16'h0000, 2'b11, 0, 4,  16'hBEEF, 1'b0};
    vecs[2]  = '{1, 1'b1, 24'h000222, 16'h1234, 2'b11, 0, 2,  16'h0000, 1'b0};
    vecs[3]  = '{1, 1'b0, 24'h000222, 16'h0000, 2'b11, 0, 4,  16'h1234, 1'b0};
    vecs[4]  = '{0, 1'b1, 24'h000010, 16'h1122, 2'b01, 0, 2,  16'h0000, 1'b0};
    vecs[5]  = '{1, 1'b0, 24'h000010, 16'h0000, 2'b11, 0, 4,  16'hBE22, 1'b0};
    vecs[6]  = '{0, 1'b1, 24'h000020, 16'hA5A5, 2'b11, 0, 2,  16'h0000, 1'b0};
    vecs[7]  = '{0, 1'b0, 24'hC00020, 16'h0000, 2'b11, 0, 4,  16'hA5A5, 1'b0};
    vecs[8]  = '{1, 1'b1, 24'hC00004, 16'h8144, 2'b11, 5, 6,  16'h0000, 1'b0};
    vecs[9]  = '{0, 1'b0, 24'hC00012, 16'h0000, 2'b11, 1, 2,  16'h5A3C, 1'b0};
    vecs[10] = '{0, 1'b0, 24'hC00000, 16'h0000, 2'b11, 0, 10, 16'h0000, 1'b1};
    vecs[11] = '{1, 1'b1, 24'hC0001F, 16'h4321, 2'b11, 0, 10, 16'h0000, 1'b1};
    vecs[12] = '{1, 1'b0, 24'hC0001E, 16'h0000, 2'b11, 8, 9,  16'h5A3C, 1'b0};

    // Reset held with both masters requesting.
    rst_n = 1'b0;
    set_master(0, 1'b1, 24'h000100, 16'h1111, 2'b11);
    set_master(1, 1'b1, 24'h000200, 16'h2222, 2'b11);
    m_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ack", m_ack, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_vdp_sel", vdp_sel, 0);
      chk("rst_vdp_rnw", vdp_rnw, 1);
      chk("rst_rdata", m_rdata, 0);
    end
    rst_n = 1'b1;

    // Continuous requests: grants alternate 0,1,0,1 starting at master 0.
    for (int t = 0; t < 4; t++) begin
      k = t % 2;
      cyc = 0;
      while (m_ack == 2'b00 && cyc < 20) begin
        tick();
        cyc++;
        if (cyc == 1) chk($sformatf("alt%0d_ram_addr", t), ram_addr, (k == 0) ? 15'h0080 : 15'h0100);
      end
      chk($sformatf("alt%0d_grant", t), m_ack, (k == 0) ? 2'b01 : 2'b10);
      chk($sformatf("alt%0d_ack_cycle", t), cyc, 2);
      if (t == 3) m_req = 2'b00;
      else        m_req[k] = 1'b0;
      tick();
      chk($sformatf("alt%0d_ack_drop", t), m_ack, 0);
      if (t < 3) m_req[k] = 1'b1;
    end

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Master 0 abandons a RAM read while master 1 waits.
    set_master(0, 1'b0, 24'h000010, 16'h0000, 2'b11);
    set_master(1, 1'b1, 24'h000300, 16'h7777, 2'b11);
    m_req = 2'b01;
    tick();
    chk("drop_ram_addr", ram_addr, 15'h0008);
    m_req = 2'b11;
    tick();
    m_req = 2'b10;
    tick();
    chk("drop_c3_ack", m_ack, 0);
    tick();
    chk("drop_c4_ack", m_ack, 0);
    chk("drop_c4_ram_en", ram_en, 0);
    chk("drop_c4_rdata", m_rdata, 16'hBE22);
    tick();
    chk("drop_c5_ack", m_ack, 0);
    chk("drop_c5_ram_en", ram_en, 1);
    chk("drop_c5_ram_addr", ram_addr, 15'h0180);
    tick();
    chk("drop_c6_ack", m_ack, 2'b10);
    m_req = 2'b00;
    tick();
    chk("drop_ack_clear", m_ack, 0);

    // Reset pulsed during a VDP wait aborts the access.
    set_master(0, 1'b0, 24'hC00008, 16'h0000, 2'b11);
    vdp_dtack_n = 1'b1;
    m_req = 2'b01;
    tick();
    chk("rstmid_vdp_sel", vdp_sel, 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstmid_vdp_sel_drop", vdp_sel, 0);
    chk("rstmid_vdp_rnw", vdp_rnw, 1);
    chk("rstmid_ack", m_ack, 0);
    rst_n = 1'b1;
    m_req = 2'b00;
    for (int i = 0; i < 12; i++) tick();
    chk("rstmid_no_ack", m_ack, 0);
    chk("rstmid_no_berr", m_berr, 0);
    run_vec(vecs[3], 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
